// File: rtl/aes_req_arbiter_pkg.sv
// Shared types and constants for the AES request arbiter slice.
package aes_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int   BLOCK_W  = 128;
  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

  function automatic int key_w(input int nk);
    return 32 * nk;
  endfunction

endpackage

// File: rtl/aes_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] sel;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = IDX_W'(j);
      if (!any_o && req_i[sel]) begin
        any_o      = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = sel;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin front end sharing one AES enc/dec core pair among NUM_REQ requesters.
// Optional AES_ARB_PERF_EN adds a saturating 16-bit completed-operation counter (op_count).
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  parameter  int Nk       = 4,
  parameter  int CORE_LAT = 2,
  localparam int KEY_W    = key_w(Nk)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_mode,
  input  logic [BLOCK_W*NUM_REQ-1:0] req_data,
  input  logic [KEY_W*NUM_REQ-1:0]   req_key,
  output logic [BLOCK_W-1:0]         core_data,
  output logic [KEY_W-1:0]           core_key,
  input  logic [BLOCK_W-1:0]         core_enc,
  input  logic [BLOCK_W-1:0]         core_dec,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [BLOCK_W-1:0]         rsp_data,
  output logic                       busy
`ifdef AES_ARB_PERF_EN
  ,output logic [15:0]               op_count
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, g_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mode_q;
  logic [BLOCK_W-1:0] data_q, rsp_q;
  logic [KEY_W-1:0]   key_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx, ptr_nxt;
  logic               gnt_any;
  logic               accept, done, hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign accept  = (state_q == IDLE) && gnt_any;
  assign done    = (state_q == WAIT) && (cnt_q == '0);
  assign hs      = (state_q == RESP) && rsp_ready[g_q];
  assign ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready[g_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is combinational from the picker, so it must be masked while rst is high.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != IDLE);
    if (state_q == IDLE && !rst) req_ready = gnt;
    if (state_q == RESP)         rsp_valid[g_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      g_q    <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_DEC;
      data_q <= '0;
      key_q  <= '0;
      rsp_q  <= '0;
    end else begin
      if (accept) begin
        data_q <= req_data[BLOCK_W*gnt_idx +: BLOCK_W];
        key_q  <= req_key[KEY_W*gnt_idx +: KEY_W];
        mode_q <= req_mode[gnt_idx];
        g_q    <= gnt_idx;
        ptr_q  <= ptr_nxt;
        cnt_q  <= CNT_W'(CORE_LAT - 1);
      end else if (state_q == WAIT) begin
        if (done) rsp_q <= (mode_q == MODE_ENC) ? core_enc : core_dec;
        else      cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign core_data = data_q;
  assign core_key  = key_q;
  assign rsp_data  = rsp_q;

`ifdef AES_ARB_PERF_EN
  logic [15:0] ops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ops_q <= '0;
    else if (hs && ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
  end

  assign op_count = ops_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Round-robin scheduler that shares one AES Encryption/Decryption core pair among NUM_REQ requesters, e.g. the SPI slave front-end and an on-chip host port.
- Accepts one request at a time (data, key, mode) and registers the operands onto the shared core.
- Waits CORE_LAT cycles for the core outputs to settle, then returns the selected result to the winning requester through a valid/ready response handshake.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
Nk, 4, key length in 32-bit words; key width KEY_W = 32*Nk
CORE_LAT, 2, cycles from operand launch to result capture (>=1; covers the combinational core's settling time)

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  request accepted, one-hot
req_mode  in  NUM_REQ  1 = encrypt, 0 = decrypt, per requester
req_data  in  128*NUM_REQ  block per requester; requester i occupies slice [128*i +: 128]
req_key  in  KEY_W*NUM_REQ  key per requester; requester i occupies slice [KEY_W*i +: KEY_W]
core_data  out  128  shared core data input
core_key  out  KEY_W  shared core key input
core_enc  in  128  encryption core result
core_dec  in  128  decryption core result
rsp_valid  out  NUM_REQ  response valid, one-hot to the granted requester
rsp_ready  in  NUM_REQ  response taken, per requester
rsp_data  out  128  result block
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous, active-high (rst); clock clk, rising edge.
- While rst is high, or on rst mid-operation: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, core_data=0, core_key=0, busy=0, priority pointer=0, latency counter=0. Any in-flight operation is discarded.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching from the priority pointer upward with wrap-around.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits stay 0.
  - At the clock edge: capture req_data[g], req_key[g], req_mode[g] into core_data, core_key, mode_q; store g; pointer <= (g+1) mod NUM_REQ; counter <= CORE_LAT-1; go to WAIT.
  - If no req_valid bit is set: remain in IDLE and keep the pointer unchanged.
- WAIT:
  - core_data and core_key stay stable; req_ready=0.
  - When counter==0: rsp_data <= (mode_q ? core_enc : core_dec); go to RESP. Otherwise decrement the counter.
  - rsp_valid therefore rises exactly CORE_LAT cycles after the accept edge.
- RESP:
  - rsp_valid[g]=1 and rsp_data is held stable until rsp_ready[g]=1. rsp_ready bits of non-granted requesters are ignored.
  - On the handshake edge: rsp_valid <= 0; go to IDLE. The next grant is evaluated no earlier than the following cycle (IDLE lasts at least one cycle).
- Core inputs keep their last values after completion; they are cleared only by reset.
- Requesters must hold req_* stable while req_valid is high and until req_ready. Dropping req_valid before the grant withdraws the request without penalty.
- Simultaneous requests: exactly one is granted per accept. Under continuous requests from all ports, grant order rotates fairly, e.g. 0,1,0,1 with NUM_REQ=2.
- A requester may reassert req_valid in the same cycle as its own rsp handshake. It competes normally at the next IDLE.
- Throughput: one operation per CORE_LAT+2 cycles minimum (accept + CORE_LAT + response handshake).

Optional Feature:
AES_ARB_PERF_EN
- Defined: adds output op_count (16 bits) plus one internal counter.
  - op_count increments on every completed response handshake and saturates at 0xFFFF.
  - Reset value 0; also cleared on rst mid-operation.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package aes_arb_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - constants BLOCK_W=128, MODE_ENC=1, MODE_DEC=0;
  - function key_w(Nk)=32*Nk.
- Sub-module rr_arbiter (NUM_REQ): combinational.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and its index.
  - Reused by the top for req_ready and the pointer update.

Test Plan:
- Req0 encrypt, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> req_ready[0] pulses 1 cycle; rsp_valid[0] exactly 2 cycles later; rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Req1 decrypt, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a -> rsp_valid[1] only; rsp_data=00112233445566778899aabbccddeeff.
- Req0 and req1 held valid continuously for 6 operations, rsp_ready tied 1 -> grant sequence 0,1,0,1,0,1; each result matches its own mode and key.
- rsp_ready[0] held low 10 cycles with req1 pending -> rsp_valid[0] and rsp_data stay stable; req_ready[1] stays 0 until the response handshake completes.
- rst asserted 1 cycle in WAIT -> all outputs 0 at once; pointer 0; a fresh req1 afterwards completes normally.
- With AES_ARB_PERF_EN: 5 completed operations -> op_count=5; an aborted operation (reset) is not counted and clears op_count to 0.
